writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 156 +++++++++++++++
 tb/tb_writeback_queue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// Writeback queue: buffers decoded results, presents the oldest to the
// register file, and offers a combinational bypass lookup.
// Ports:
//   clk, rst (sync, active-high), flush
//   in_*: offer (valid/ready), result select (jump, mem_access), dest and flags
//   alu_data, mem_data, pc: result sources captured at enqueue
//   wb_*: head entry (valid/ready), driven from stored state only
//   lookup_addr, lookup_hit, lookup_data: youngest-match bypass
//   count: number of queued entries

`ifndef PC_SIZE
`define PC_SIZE 16
`endif

module writeback_queue #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int PC_W   = `PC_SIZE,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_use_rw,
    input  logic [ADDR_W-1:0]            in_rw_addr,
    input  logic                         in_write_ps,
    input  logic                         in_jump,
    input  logic                         in_mem_access,
    input  logic [DATA_W-1:0]            alu_data,
    input  logic [DATA_W-1:0]            mem_data,
    input  logic [PC_W-1:0]              pc,
    output logic                         wb_valid,
    input  logic                         wb_ready,
    output logic                         wb_use_rw,
    output logic [ADDR_W-1:0]            wb_rw_addr,
    output logic [DATA_W-1:0]            wb_data,
    output logic                         wb_write_ps,
    output logic                         wb_ps,
    input  logic [ADDR_W-1:0]            lookup_addr,
    output logic                         lookup_hit,
    output logic [DATA_W-1:0]            lookup_data,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [DEPTH-1:0]  vld;
    logic [DEPTH-1:0]  use_q;
    logic [DEPTH-1:0]  wps_q;
    logic [DEPTH-1:0]  ps_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [DATA_W-1:0] pc_ext;
    logic [DATA_W-1:0] ent_data;
    logic              push;
    logic              pop;

    generate
        if (PC_W >= DATA_W) begin : g_pc_trunc
            assign pc_ext = pc[DATA_W-1:0];
        end else begin : g_pc_zext
            assign pc_ext = {{(DATA_W-PC_W){1'b0}}, pc};
        end
    endgenerate

    // Link value wins over load data, load data over ALU result.
    always_comb begin
        ent_data = alu_data;
        if (in_jump)
            ent_data = pc_ext + DATA_W'(1);
        else if (in_mem_access)
            ent_data = mem_data;
    end

    assign in_ready = (cnt < FULL);
    assign wb_valid = (cnt != '0);
    assign count    = cnt;

    // Offers that write nothing are accepted but never stored.
    assign push = in_valid & in_ready & ~flush
                & (in_use_rw | in_write_ps);
    assign pop  = wb_valid & wb_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            vld    <= '0;
            use_q  <= '0;
            wps_q  <= '0;
            ps_q   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            vld    <= '0;
        end else begin
            if (push) begin
                wr_ptr        <= wr_ptr + PTR_W'(1);
                vld[wr_ptr]   <= 1'b1;
                use_q[wr_ptr] <= in_use_rw;
                wps_q[wr_ptr] <= in_write_ps;
                ps_q[wr_ptr]  <= alu_data[0];
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + PTR_W'(1);
                vld[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage needs no reset; validity lives in vld.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            addr_q[wr_ptr] <= in_rw_addr;
            data_q[wr_ptr] <= ent_data;
        end
    end

    // Walk oldest to youngest so the youngest match is the last one kept.
    logic [PTR_W-1:0] lk_idx;
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        lk_idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = rd_ptr + PTR_W'(i);
            if (vld[lk_idx] && use_q[lk_idx]
                && addr_q[lk_idx] == lookup_addr) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[lk_idx];
            end
        end
    end

    assign wb_use_rw   = wb_valid & use_q[rd_ptr];
    assign wb_write_ps = wb_valid & wps_q[rd_ptr];
    assign wb_ps       = wb_valid & ps_q[rd_ptr];
    assign wb_rw_addr  = wb_valid ? addr_q[rd_ptr] : '0;
    assign wb_data     = wb_valid ? data_q[rd_ptr] : '0;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue (DEPTH=4, DATA_W=16, ADDR_W=4, PC_W=16).
// Inputs change 1 time unit after each rising edge; outputs checked there.

module tb_writeback_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_use_rw;
    logic [3:0]  in_rw_addr;
    logic        in_write_ps;
    logic        in_jump;
    logic        in_mem_access;
    logic [15:0] alu_data;
    logic [15:0] mem_data;
    logic [15:0] pc;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_use_rw;
    logic [3:0]  wb_rw_addr;
    logic [15:0] wb_data;
    logic        wb_write_ps;
    logic        wb_ps;
    logic [3:0]  lookup_addr;
    logic        lookup_hit;
    logic [15:0] lookup_data;
    logic [2:0]  count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    writeback_queue #(
        .DATA_W(16), .ADDR_W(4), .PC_W(16), .DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_use_rw(in_use_rw), .in_rw_addr(in_rw_addr),
        .in_write_ps(in_write_ps), .in_jump(in_jump),
        .in_mem_access(in_mem_access),
        .alu_data(alu_data), .mem_data(mem_data), .pc(pc),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_use_rw(wb_use_rw), .wb_rw_addr(wb_rw_addr),
        .wb_data(wb_data), .wb_write_ps(wb_write_ps), .wb_ps(wb_ps),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
        .lookup_data(lookup_data), .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; in_valid = 0; in_use_rw = 0; in_rw_addr = 0;
        in_write_ps = 0; in_jump = 0; in_mem_access = 0;
        alu_data = 0; mem_data = 0; pc = 0;
    endtask

    task automatic offer(input logic use_rw, input logic [3:0] a,
                         input logic [15:0] d);
        in_valid = 1; in_use_rw = use_rw; in_rw_addr = a;
        in_write_ps = 0; in_jump = 0; in_mem_access = 0;
        alu_data = d;
    endtask

    initial begin
        idle();
        wb_ready = 0; lookup_addr = 0;

        // Reset, with an offer present that must be dropped
        rst = 1;
        tick();
        offer(1, 4'd3, 16'h7777);
        tick();
        rst = 0;
        idle();
        chk("rst_count", count, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_addr", wb_rw_addr, 0);
        lookup_addr = 4'd3;
        #1;
        chk("rst_lookup_hit", lookup_hit, 0);

        // Basic push; entry being pushed is invisible to lookup
        offer(1, 4'd3, 16'h1234);
        #1;
        chk("push_lookup_self", lookup_hit, 0);
        tick();
        idle();
        chk("push_wb_valid", wb_valid, 1);
        chk("push_wb_addr", wb_rw_addr, 3);
        chk("push_wb_data", wb_data, 16'h1234);
        chk("push_count", count, 1);
        chk("push_wb_use_rw", wb_use_rw, 1);
        chk("push_lookup_hit", lookup_hit, 1);
        chk("push_lookup_data", lookup_data, 16'h1234);

        // Pop it
        wb_ready = 1;
        tick();
        wb_ready = 0;
        chk("pop_count", count, 0);
        chk("pop_wb_valid", wb_valid, 0);
        chk("pop_wb_data", wb_data, 0);

        // Data priority: jump over mem, pc wraps
        offer(1, 4'd1, 16'h0005);
        in_jump = 1; in_mem_access = 1; pc = 16'hFFFF;
        mem_data = 16'hBEEF;
        tick();
        offer(1, 4'd2, 16'h0005);
        in_mem_access = 1; mem_data = 16'hBEEF;
        tick();
        offer(1, 4'd2, 16'h0005);
        in_jump = 1; pc = 16'h0010;
        tick();
        idle();
        chk("jmp_wrap_data", wb_data, 16'h0000);
        chk("prio_count", count, 3);
        wb_ready = 1;
        tick();
        chk("mem_data", wb_data, 16'hBEEF);
        tick();
        chk("jmp_link_data", wb_data, 16'h0011);
        tick();
        wb_ready = 0;
        chk("prio_drained", count, 0);

        // Full and backpressure
        for (int i = 0; i < 4; i++) begin
            offer(1, 4'(4 + i), 16'h00A0 + 16'(i));
            tick();
        end
        offer(1, 4'd8, 16'h00A4);
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        tick();
        chk("full_5th_dropped", count, 4);
        chk("full_hold_data", wb_data, 16'h00A0);
        chk("full_hold_addr", wb_rw_addr, 4);
        // Full with wb_ready: pop only, no pass-through push
        offer(1, 4'd9, 16'h00A5);
        wb_ready = 1;
        tick();
        idle();
        chk("full_pop_count", count, 3);
        chk("drain_a1", wb_data, 16'h00A1);
        tick();
        chk("drain_a2", wb_data, 16'h00A2);
        chk("drain_a2_count", count, 2);
        tick();
        chk("drain_a3", wb_data, 16'h00A3);
        // Simultaneous push and pop keeps count
        offer(1, 4'd9, 16'h00A6);
        tick();
        idle();
        chk("pushpop_count", count, 1);
        chk("pushpop_data", wb_data, 16'h00A6);
        tick();
        wb_ready = 0;
        chk("drain_empty", wb_valid, 0);

        // Bypass: youngest match wins, use_rw=0 never hits
        offer(1, 4'd5, 16'h0011);
        tick();
        offer(1, 4'd5, 16'h0022);
        tick();
        offer(0, 4'd5, 16'h0033);
        in_write_ps = 1;
        tick();
        idle();
        lookup_addr = 4'd5;
        #1;
        chk("byp_hit", lookup_hit, 1);
        chk("byp_data", lookup_data, 16'h0022);
        lookup_addr = 4'd6;
        #1;
        chk("byp_miss_hit", lookup_hit, 0);
        chk("byp_miss_data", lookup_data, 0);

        // Flush overrides push and pop at count=3
        chk("pre_flush_count", count, 3);
        offer(1, 4'd6, 16'h0044);
        flush = 1;
        wb_ready = 1;
        tick();
        idle();
        wb_ready = 0;
        chk("flush_count", count, 0);
        chk("flush_wb_valid", wb_valid, 0);
        chk("flush_lookup", lookup_hit, 0);

        // Bubble consumed, not stored
        offer(0, 4'd0, 16'h0009);
        #1;
        chk("bubble_ready", in_ready, 1);
        tick();
        idle();
        chk("bubble_count", count, 0);

        // Predicate-only entry
        offer(0, 4'd0, 16'h0001);
        in_write_ps = 1;
        tick();
        idle();
        chk("ps_count", count, 1);
        chk("ps_write", wb_write_ps, 1);
        chk("ps_value", wb_ps, 1);
        chk("ps_use_rw", wb_use_rw, 0);

        // Reset mid-stream
        offer(1, 4'd7, 16'h0055);
        tick();
        idle();
        chk("mid_count", count, 2);
        lookup_addr = 4'd7;
        rst = 1;
        tick();
        rst = 0;
        chk("mrst_count", count, 0);
        chk("mrst_wb_valid", wb_valid, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_wps", wb_write_ps, 0);
        chk("mrst_ps", wb_ps, 0);
        chk("mrst_data", wb_data, 0);
        chk("mrst_lookup", lookup_hit, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
